// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice: opcodes, FSM states and
// instruction field positions.
package alu_pkg;

    localparam int DATA_W  = 4;
    localparam int RADDR_W = 2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam int OP_HI = 9;
    localparam int OP_LO = 6;
    localparam int RD_HI = 5;
    localparam int RD_LO = 4;
    localparam int RA_HI = 3;
    localparam int RA_LO = 2;
    localparam int RB_HI = 1;
    localparam int RB_LO = 0;

    // Opcodes forwarded to the external ALU and written back from its result.
    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
            OP_NAND, OP_SHL, OP_SHR, OP_XOR, OP_XNOR: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port cleared by reset, three
// combinational read ports (two operands plus debug).
module alu_regfile #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int NREG    = 4,
    parameter int RADDR_W = alu_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] ra_addr,
    input  logic [RADDR_W-1:0] rb_addr,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  ra_data,
    output logic [DATA_W-1:0]  rb_data,
    output logic [DATA_W-1:0]  dbg_data
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// Three-state instruction sequencer around an external combinational ALU:
// read operands on accept, capture ALU outputs in EXEC, write back in WB.
module alu_exec_seq #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int NREG    = 4,
    parameter int RADDR_W = alu_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [9:0]         instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic               alu_c,
    input  logic               alu_z,
    input  logic               alu_n,
    output logic               done,
    output logic               err,
    output logic [2:0]         flags,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    import alu_pkg::*;

    state_t state, state_nxt;

    logic [9:0]         ir_p0;
    logic [DATA_W-1:0]  y_p1;
    logic               c_p1, z_p1, n_p1;
    logic [DATA_W-1:0]  ra_data, rb_data;
    logic [3:0]         op_p0;
    logic [RADDR_W-1:0] rd_p0;
    logic [DATA_W-1:0]  imm_p0;
    logic               is_ldi, is_alu, is_illegal;
    logic               accept, wb_en;
    logic [DATA_W-1:0]  wb_data;

    assign accept     = instr_valid & instr_ready;
    assign op_p0      = ir_p0[OP_HI:OP_LO];
    assign rd_p0      = RADDR_W'(ir_p0[RD_HI:RD_LO]);
    assign imm_p0     = DATA_W'(ir_p0[RA_HI:RB_LO]);
    assign is_ldi     = (op_p0 == OP_LDI);
    assign is_alu     = is_alu_op(op_p0);
    assign is_illegal = !is_ldi && !is_alu;
    assign wb_en      = (state == S_WB) && (is_ldi || is_alu);
    assign wb_data    = is_ldi ? imm_p0 : y_p1;

    alu_regfile #(
        .DATA_W  (DATA_W),
        .NREG    (NREG),
        .RADDR_W (RADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_en),
        .waddr    (rd_p0),
        .wdata    (wb_data),
        .ra_addr  (RADDR_W'(instr[RA_HI:RA_LO])),
        .rb_addr  (RADDR_W'(instr[RB_HI:RB_LO])),
        .dbg_addr (dbg_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // done/err are masked while reset is asserted so a discarded instruction never retires.
    always_comb begin
        instr_ready = (state == S_IDLE);
        done        = (state == S_WB) && !rst;
        err         = (state == S_WB) && !rst && is_illegal;
    end

    // Stage p0: latch instruction and operands at accept; they hold through EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_p0   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (accept) begin
            ir_p0   <= instr;
            alu_a   <= ra_data;
            alu_b   <= rb_data;
            alu_sel <= instr[OP_HI:OP_LO];
        end
    end

    // Stage p1: hold ALU outputs sampled at the end of EXEC, then commit flags in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p1  <= '0;
            c_p1  <= 1'b0;
            z_p1  <= 1'b0;
            n_p1  <= 1'b0;
            flags <= '0;
        end else begin
            if (state == S_EXEC) begin
                y_p1 <= alu_y;
                c_p1 <= alu_c;
                z_p1 <= alu_z;
                n_p1 <= alu_n;
            end
            if (wb_en) begin
                flags <= is_ldi ? {1'b0, (imm_p0 == '0), imm_p0[DATA_W-1]}
                                : {c_p1, z_p1, n_p1};
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: emulates the external ALU, runs a directed vector
// table, a held-valid sequence, random instructions and a mid-flight reset.
module tb_alu_exec_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [9:0] instr;
    logic [3:0] alu_a, alu_b, alu_sel, alu_y;
    logic       alu_c, alu_z, alu_n;
    logic       done, err;
    logic [2:0] flags;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int passed = 0;
    int total  = 0;

    logic [3:0] m_reg [4];
    logic [2:0] m_flags;

    always #5 clk = ~clk;

    alu_exec_seq dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_y       (alu_y),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .done        (done),
        .err         (err),
        .flags       (flags),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Arithmetic view of the ALU: returns {C, Z, N, Y[3:0]}.
    function automatic logic [6:0] alu_ref(input logic [3:0] sel, input logic [3:0] av, input logic [3:0] bv);
        int a, b, y, c;
        logic [3:0] y4;
        a = int'(av);
        b = int'(bv);
        c = 0;
        case (sel)
            4'd0: begin y = a + b; c = (y > 15) ? 1 : 0; end
            4'd1: begin y = a - b; c = (a < b) ? 1 : 0; end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = 15 - a;
            4'd5: y = 15 - (a & b);
            4'd6: begin y = a * 2; c = (a >= 8) ? 1 : 0; end
            4'd7: begin y = a / 2; c = a % 2; end
            4'd8: y = a ^ b;
            4'd9: y = 15 - (a ^ b);
            default: y = 0;
        endcase
        y  = (y + 16) % 16;
        y4 = 4'(y);
        return {c[0], (y == 0), (y >= 8), y4};
    endfunction

    logic [6:0] alu_out;
    assign alu_out = alu_ref(alu_sel, alu_a, alu_b);
    assign alu_y   = alu_out[3:0];
    assign alu_n   = alu_out[4];
    assign alu_z   = alu_out[5];
    assign alu_c   = alu_out[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk(input int op, input int rd, input int ra, input int rb);
        return {4'(op), 2'(rd), 2'(ra), 2'(rb)};
    endfunction

    task automatic model_apply(input logic [9:0] ins);
        logic [3:0] op;
        logic [1:0] rd;
        logic [3:0] imm;
        logic [6:0] r;
        op  = ins[9:6];
        rd  = ins[5:4];
        imm = ins[3:0];
        if (op <= 4'd9) begin
            r = alu_ref(op, m_reg[ins[3:2]], m_reg[ins[1:0]]);
            m_reg[rd] = r[3:0];
            m_flags   = r[6:4];
        end else if (op == 4'd10) begin
            m_reg[rd] = imm;
            m_flags   = {1'b0, (imm == 4'd0), imm[3]};
        end
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk(name, dbg_data, m_reg[i]);
        end
    endtask

    // Issue one instruction from IDLE and follow it to retirement.
    task automatic do_instr(input logic [9:0] ins);
        logic [3:0] op;
        op = ins[9:6];
        chk("ready_idle", instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 10'($urandom);
        chk("done_exec", done, 1'b0);
        chk("ready_exec", instr_ready, 1'b0);
        chk("alu_sel", alu_sel, op);
        chk("alu_a", alu_a, m_reg[ins[3:2]]);
        chk("alu_b", alu_b, m_reg[ins[1:0]]);
        @(posedge clk); #1;
        chk("done_wb", done, 1'b1);
        chk("err_wb", err, (op > 4'd10));
        model_apply(ins);
        @(posedge clk); #1;
        chk("done_after", done, 1'b0);
        chk("flags", flags, m_flags);
        dbg_addr = ins[5:4];
        #1;
        chk("dbg_rd", dbg_data, m_reg[ins[5:4]]);
    endtask

    typedef struct {
        logic [9:0] ins;
        logic [3:0] exp_rd;
        logic [2:0] exp_flags;
    } vec_t;

    vec_t tbl [15];
    logic [9:0] hl [4];
    int k;
    logic [9:0] cur;

    initial begin
        tbl[0]  = '{mk(10, 0, 1, 0), 4'd4,  3'b000};
        tbl[1]  = '{mk(10, 1, 0, 2), 4'd2,  3'b000};
        tbl[2]  = '{mk(0,  2, 0, 1), 4'd6,  3'b000};
        tbl[3]  = '{mk(10, 0, 2, 1), 4'd9,  3'b001};
        tbl[4]  = '{mk(10, 1, 1, 3), 4'd7,  3'b000};
        tbl[5]  = '{mk(0,  3, 0, 1), 4'd0,  3'b110};
        tbl[6]  = '{mk(10, 0, 0, 0), 4'd0,  3'b010};
        tbl[7]  = '{mk(10, 1, 0, 0), 4'd0,  3'b010};
        tbl[8]  = '{mk(1,  2, 0, 1), 4'd0,  3'b010};
        tbl[9]  = '{mk(10, 0, 0, 2), 4'd2,  3'b000};
        tbl[10] = '{mk(10, 1, 1, 1), 4'd5,  3'b000};
        tbl[11] = '{mk(1,  2, 0, 1), 4'd13, 3'b101};
        tbl[12] = '{mk(8,  3, 2, 2), 4'd0,  3'b010};
        tbl[13] = '{mk(12, 1, 0, 0), 4'd5,  3'b010};
        tbl[14] = '{mk(3,  0, 1, 2), 4'd13, 3'b001};

        for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
        m_flags     = 3'b000;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_flags", flags, 3'b000);
        chk("rst_alu_a", alu_a, 4'd0);
        chk("rst_alu_b", alu_b, 4'd0);
        chk("rst_alu_sel", alu_sel, 4'd0);
        check_regs("rst_reg");

        for (int i = 0; i < 15; i++) begin
            do_instr(tbl[i].ins);
            chk("tbl_rd", dbg_data, tbl[i].exp_rd);
            chk("tbl_flags", flags, tbl[i].exp_flags);
        end

        // instr_valid held high for 10 cycles: one accept every third cycle.
        hl[0] = mk(0, 0, 1, 2);
        hl[1] = mk(2, 1, 0, 3);
        hl[2] = mk(6, 2, 0, 0);
        hl[3] = mk(10, 3, 1, 1);
        k = 0;
        cur = '0;
        instr_valid = 1'b1;
        instr = hl[0];
        for (int cyc = 0; cyc < 12; cyc++) begin
            logic acc;
            if (cyc < 10) chk("hold_ready", instr_ready, (cyc % 3 == 0));
            if (cyc % 3 == 1) chk("hold_sel_exec", alu_sel, cur[9:6]);
            if (cyc % 3 == 2) begin
                chk("hold_sel_wb", alu_sel, cur[9:6]);
                chk("hold_done", done, 1'b1);
                model_apply(cur);
            end
            acc = instr_ready & instr_valid;
            if (acc) begin
                cur = instr;
                k++;
            end
            @(posedge clk); #1;
            if (k < 4) instr = acc ? hl[k] : 10'($urandom);
            else       instr = 10'($urandom);
            instr_valid = (cyc + 1 < 10);
        end
        chk("hold_accepts", 16'(k), 16'd4);
        check_regs("hold_reg");
        chk("hold_flags", flags, m_flags);

        for (int i = 0; i < 40; i++) begin
            do_instr(10'($urandom));
        end
        check_regs("rand_reg");

        // Reset while ADD r2 is in EXEC: the instruction must vanish.
        chk("pre_rst_ready", instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr       = mk(0, 2, 0, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst         = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
        m_flags = 3'b000;
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_ready", instr_ready, 1'b1);
        chk("mid_rst_flags", flags, 3'b000);
        chk("mid_rst_sel", alu_sel, 4'd0);
        dbg_addr = 2'd2;
        #1;
        chk("mid_rst_r2", dbg_data, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_done", done, 1'b0);
        end
        check_regs("mid_rst_reg");
        do_instr(mk(10, 2, 3, 1));
        do_instr(mk(0, 1, 2, 2));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
Instruction sequencer and register-file stage that sits directly upstream and downstream of the 4-bit ALU_5.
- Accepts one instruction per handshake.
- Reads two operands from a 4x4-bit register file and drives the ALU's A, B and sel inputs.
- Captures the ALU's Y, C_out, Z_out and N_out, then writes the result back and updates a flag register.
- ALU_5 is instantiated externally by the parent and wired through the alu_* ports.

Parameters:
DATA_W, 4, operand/result width; must match ALU_5.
NREG, 4, number of registers in the register file.
RADDR_W, 2, register address width (log2 NREG).

Ports:
clk  in  1  single clock, all state updates on its rising edge.
rst  in  1  synchronous reset, active-high.
instr_valid  in  1  instruction present.
instr_ready  out  1  block can accept an instruction.
instr  in  10  {op[9:6], rd[5:4], ra[3:2], rb[1:0]}; for LDI the immediate is {ra,rb}.
alu_a  out  DATA_W  to ALU_5 A.
alu_b  out  DATA_W  to ALU_5 B.
alu_sel  out  4  to ALU_5 sel.
alu_y  in  DATA_W  from ALU_5 Y.
alu_c  in  1  from ALU_5 C_out.
alu_z  in  1  from ALU_5 Z_out.
alu_n  in  1  from ALU_5 N_out.
done  out  1  one-cycle pulse when an instruction retires.
err  out  1  valid with done; 1 = illegal opcode.
flags  out  3  registered {C,Z,N} of last retired ALU/LDI instruction.
dbg_addr  in  RADDR_W  debug read address.
dbg_data  out  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset values: state=IDLE; all registers=0; flags=0; alu_a/alu_b/alu_sel=0; done=0; err=0; instr_ready=1.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 NAND, 6 SHL, 7 SHR, 8 XOR, 9 XNOR, passed unchanged to alu_sel.
  - 10 LDI.
  - 11-15 illegal.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid: latch instr.
  - Load alu_a=reg[ra], alu_b=reg[rb], alu_sel=op; these are registered outputs, stable for all of EXEC.
  - Go to EXEC.
- EXEC:
  - instr_ready=0.
  - ALU is combinational; at the end of this cycle capture alu_y, alu_c, alu_z, alu_n into holding regs.
  - Go to WB.
- WB:
  - instr_ready=0; done=1 for exactly this cycle.
  - Legal ALU op: reg[rd]<=held Y; flags<={C,Z,N} held.
  - LDI: reg[rd]<=imm; flags<={0, imm==0, imm[3]}.
  - Illegal op: no register or flag write; err=1.
  - Go to IDLE.
- Latency: accept at cycle t, done at t+2; throughput 1 instruction per 3 cycles; no overlap.
- Handshake:
  - Transfer occurs only when instr_valid & instr_ready.
  - instr_valid held high while busy is ignored until the block returns to IDLE.
  - instr may change while not ready.
- Hazards:
  - Operands are read in the IDLE→EXEC transition and write-back occurs in WB, so rd==ra/rb is safe.
  - Back-to-back dependent instructions see the updated value.
- alu_a/alu_b/alu_sel hold their last values while in IDLE.
- NOT, SHL and SHR still drive alu_b=reg[rb]; the ALU ignores B where unused.
- Reset asserted in any state: next cycle is IDLE with all reset values; the in-flight instruction is discarded with no write and no done.
- dbg_data reflects a WB write starting the cycle after WB.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_ADD..OP_XNOR, OP_LDI.
  - State encodings S_IDLE/S_EXEC/S_WB.
  - DATA_W, RADDR_W.
  - Instruction field bit positions.
- One natural sub-module: alu_regfile.
  - NREG x DATA_W.
  - 1 synchronous write port with reset clear.
  - 3 combinational read ports: ra, rb, dbg.

Test Plan:
- LDI r0=4, LDI r1=2, ADD r2=r0+r1 -> dbg r2=6, flags={0,0,0}, each done exactly 2 cycles after accept.
- LDI r0=9, LDI r1=7, ADD r3=r0+r1 -> r3=0, flags C=1 Z=1 N=0. Then LDI r0=0, LDI r1=0, SUB r2=r0-r1 -> r2=0, Z=1.
- LDI r0=2, LDI r1=5, SUB r2=r0-r1 -> r2=4'b1101, N=1. Then XOR r3=r2^r2 (rd/ra/rb alias check) -> r3=0, Z=1.
- Opcode 4'hC with rd=r1 -> done=1, err=1, r1 and flags unchanged. Then a legal instruction retires with err=0.
- instr_valid held high for 10 cycles with 3 distinct instrs presented -> instr_ready low in EXEC/WB; exactly one accept per 3 cycles; alu_sel stable through EXEC.
- rst pulsed during EXEC of ADD r2 -> no done pulse; r2=0, flags=0, instr_ready=1 the cycle after reset deasserts.
